// File: rtl/soc_pio_gpio.sv
// soc_pio_gpio: parametrised bidirectional GPIO peripheral, Avalon-MM slave.
//   Per-bit direction, 2-flop input synchroniser, sticky edge capture with
//   write-1-to-clear, and a level interrupt gated by a mask register.
//
// Optional feature macro: SOC_PIO_GPIO_OUTSETCLR_EN
//   defined   -> word 4 (OUTSET) ORs and word 5 (OUTCLR) clears data_out bits
//   undefined -> words 4/5 behave as unmapped (writes ignored, read 0)
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[2:0]      register word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data, bits [WIDTH-1:0] used
//   readdata[31:0]    combinational read data, zero-extended
//   in_port[WIDTH]    asynchronous pin inputs
//   out_port[WIDTH]   output data register
//   oe[WIDTH]         per-bit output enable (direction register)
//   irq               level interrupt, active high
//
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET, 5 OUTCLR.

module soc_pio_gpio #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter int unsigned      EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam int unsigned BUS_W = 32;

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_DIR     = 3'd1;
   localparam logic [2:0] A_IRQMASK = 3'd2;
   localparam logic [2:0] A_EDGECAP = 3'd3;
`ifdef SOC_PIO_GPIO_OUTSETCLR_EN
   localparam logic [2:0] A_OUTSET  = 3'd4;
   localparam logic [2:0] A_OUTCLR  = 3'd5;
`endif

   logic             wr_en;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] rd_word;
   logic             unused_wdata;

   assign wr_en = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];

   // Upper write-data bits are architecturally ignored when WIDTH < 32.
   assign unused_wdata = ^writedata;

   // Next value of the output data register.
`ifdef SOC_PIO_GPIO_OUTSETCLR_EN
   always_comb begin
      data_nxt = data_out;
      if (wr_en) begin
         case (address)
            A_DATA:   data_nxt = wdata;
            A_OUTSET: data_nxt = data_out | wdata;
            A_OUTCLR: data_nxt = data_out & ~wdata;
            default:  data_nxt = data_out;
         endcase
      end
   end
`else
   assign data_nxt = (wr_en && (address == A_DATA)) ? wdata : data_out;
`endif

   // Control registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
         dir      <= RESET_DIR;
         irqmask  <= '0;
      end else begin
         data_out <= data_nxt;
         if (wr_en && (address == A_DIR)) begin
            dir <= wdata;
         end
         if (wr_en && (address == A_IRQMASK)) begin
            irqmask <= wdata;
         end
      end
   end

   // Input synchroniser plus one history stage for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1      <= '0;
         in_sync <= '0;
         in_prev <= '0;
      end else begin
         s1      <= in_port;
         in_sync <= s1;
         in_prev <= in_sync;
      end
   end

   // Edge polarity selection.
   if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = in_sync & ~in_prev;
   end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~in_sync & in_prev;
   end else begin : g_any
      assign edge_det = in_sync ^ in_prev;
   end

   assign cap_clr = (wr_en && (address == A_EDGECAP)) ? wdata : '0;

   // Sticky capture; a new edge overrides a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap <= '0;
      end else begin
         edgecap <= (edgecap & ~cap_clr) | edge_det;
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      rd_word = '0;
      case (address)
         A_DATA:    rd_word = (dir & data_out) | (~dir & in_sync);
         A_DIR:     rd_word = dir;
         A_IRQMASK: rd_word = irqmask;
         A_EDGECAP: rd_word = edgecap;
         default:   rd_word = '0;
      endcase
   end

   assign readdata = BUS_W'(rd_word);
   assign out_port = data_out;
   assign oe       = dir;
   assign irq      = |(edgecap & irqmask);

endmodule
